// File: rtl/tlul_pkg.sv
// TL-UL bus types shared by the gate and its neighbours.
// Response integrity uses a compact parity code over the payload.
package tlul_pkg;

    localparam int TL_AW    = 32;
    localparam int TL_DW    = 32;
    localparam int TL_AIW   = 8;
    localparam int TL_SZW   = 2;
    localparam int TL_DBW   = TL_DW / 8;
    localparam int TL_RSVDW = 9;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [TL_RSVDW-1:0] rsvd;
        logic [6:0]          cmd_intg;
        logic [6:0]          data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic              d_sink;
        logic [TL_DW-1:0]  d_data;
        tl_d_user_t        d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

    function automatic logic [6:0] tl_intg7(logic [TL_DW-1:0] d);
        logic [6:0] p;
        p = '0;
        for (int k = 0; k < 7; k++) begin
            p[k] = ^(d & (32'h8E1D_4B73 << k)) ^ ^(d & (32'h3C96_A5F1 >> k));
        end
        return p;
    endfunction

endpackage

// File: rtl/tlul_racl_gate_pkg.sv
// Constants and small helpers for the TL-UL RACL gate.
package tlul_racl_gate_pkg;

    import tlul_pkg::*;

    localparam logic [TL_DW-1:0] ErrRspData = '1;

    function automatic logic tl_a_is_read(tl_a_op_e op);
        return op == Get;
    endfunction

    function automatic tl_d_op_e err_rsp_opcode(logic read);
        return read ? AccessAckData : AccessAck;
    endfunction

endpackage

// File: rtl/top_racl_pkg.sv
// Top-level RACL types: roles, policies, error log and helpers.
// Shared by the TL-UL gate and SRAM range checkers.
package top_racl_pkg;

    localparam int NrRaclRoles    = 2;
    localparam int RaclRoleWidth  = 1;
    localparam int NrCtnUidBits   = 8;
    localparam int NrRaclPolicies = 2;

    typedef logic [RaclRoleWidth-1:0] racl_role_t;
    typedef logic [NrRaclRoles-1:0]   racl_role_vec_t;
    typedef logic [NrCtnUidBits-1:0]  ctn_uid_t;

    typedef struct packed {
        racl_role_vec_t read_perm;
        racl_role_vec_t write_perm;
    } racl_policy_t;

    typedef racl_policy_t [NrRaclPolicies-1:0] racl_policy_vec_t;

    typedef struct packed {
        logic                     valid;
        logic                     overflow;
        racl_role_t               racl_role;
        ctn_uid_t                 ctn_uid;
        logic                     read_access;
        logic [tlul_pkg::TL_AW-1:0] request_address;
    } racl_error_log_t;

    function automatic racl_role_t tlul_extract_racl_role_bits(
        logic [tlul_pkg::TL_RSVDW-1:0] rsvd
    );
        return racl_role_t'(rsvd);
    endfunction

    function automatic ctn_uid_t tlul_extract_ctn_uid_bits(
        logic [tlul_pkg::TL_RSVDW-1:0] rsvd
    );
        return ctn_uid_t'(rsvd >> RaclRoleWidth);
    endfunction

    function automatic logic racl_access_allowed(
        racl_policy_t policy,
        racl_role_t   role,
        logic         read
    );
        racl_role_vec_t perm;
        racl_role_vec_t onehot;
        perm   = read ? policy.read_perm : policy.write_perm;
        onehot = racl_role_vec_t'(1) << role;
        return |(perm & onehot);
    endfunction

endpackage

// File: rtl/tlul_racl_err_log.sv
// First-denial log register with overflow flag and clear.
module tlul_racl_err_log
    import tlul_pkg::*;
    import top_racl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             capture_i,
    input  logic             clr_i,
    input  racl_role_t       role_i,
    input  ctn_uid_t         ctn_uid_i,
    input  logic             read_i,
    input  logic [TL_AW-1:0] addr_i,
    output racl_error_log_t  log_o
);

    racl_error_log_t log_q, log_d;

    // Clear first so a same-cycle denial lands as a fresh entry.
    always_comb begin
        log_d = log_q;
        if (clr_i) begin
            log_d = '0;
        end
        if (capture_i) begin
            if (!log_d.valid) begin
                log_d.valid           = 1'b1;
                log_d.overflow        = 1'b0;
                log_d.racl_role       = role_i;
                log_d.ctn_uid         = ctn_uid_i;
                log_d.read_access     = read_i;
                log_d.request_address = addr_i;
            end else begin
                log_d.overflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            log_q <= '0;
        end else begin
            log_q <= log_d;
        end
    end

    assign log_o = log_q;

endmodule

// File: rtl/tlul_rsp_intg_gen.sv
// Regenerates D-channel response and data integrity.
module tlul_rsp_intg_gen
    import tlul_pkg::*;
(
    input  tl_d2h_t tl_i,
    output tl_d2h_t tl_o
);

    logic [TL_DW-1:0] rsp_payload;

    always_comb begin
        rsp_payload           = TL_DW'({tl_i.d_opcode, tl_i.d_size, tl_i.d_error});
        tl_o                  = tl_i;
        tl_o.d_user.rsp_intg  = tl_intg7(rsp_payload);
        tl_o.d_user.data_intg = tl_intg7(tl_i.d_data);
    end

endmodule

// File: rtl/tlul_racl_gate.sv
// TL-UL RACL gate: forwards permitted requests, answers denied
// ones locally with an error response and logs the first denial.
module tlul_racl_gate
    import tlul_pkg::*;
    import top_racl_pkg::*;
    import tlul_racl_gate_pkg::*;
#(
    parameter bit          EnableRacl     = 1'b1,
    parameter int unsigned RaclPolicySel  = 0,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  racl_policy_vec_t racl_policies_i,
    input  tl_h2d_t          tl_h_i,
    output tl_d2h_t          tl_h_o,
    output tl_h2d_t          tl_d_o,
    input  tl_d2h_t          tl_d_i,
    output racl_error_log_t  racl_error_o,
    input  logic             racl_error_clr_i
);

    logic unused_pol;
    assign unused_pol = ^racl_policies_i;

    if (EnableRacl) begin : g_racl

        typedef enum logic [1:0] {
            StIdle,
            StDrain,
            StErrRsp
        } state_e;

        localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
        localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

        state_e            state_q, state_d;
        logic [CntW-1:0]   cnt_q, cnt_d;
        logic [TL_AIW-1:0] src_q;
        logic [TL_SZW-1:0] size_q;
        logic              read_q;

        racl_role_t role;
        logic       is_read;
        logic       allowed;
        logic       cnt_full;
        logic       cnt_zero;
        logic       deny_acc;
        logic       fwd_hs;
        logic       dev_d_hs;
        tl_d2h_t    err_rsp;
        tl_d2h_t    err_rsp_intg;

        assign role     = tlul_extract_racl_role_bits(tl_h_i.a_user.rsvd);
        assign is_read  = tl_a_is_read(tl_h_i.a_opcode);
        assign allowed  = racl_access_allowed(racl_policies_i[RaclPolicySel],
                                              role, is_read);
        assign cnt_full = cnt_q == CntMax;
        assign cnt_zero = cnt_q == '0;

        always_comb begin
            err_rsp          = '0;
            err_rsp.d_valid  = 1'b1;
            err_rsp.d_opcode = err_rsp_opcode(read_q);
            err_rsp.d_size   = size_q;
            err_rsp.d_source = src_q;
            err_rsp.d_data   = ErrRspData;
            err_rsp.d_error  = 1'b1;
        end

        tlul_rsp_intg_gen u_rsp_intg (
            .tl_i (err_rsp),
            .tl_o (err_rsp_intg)
        );

        always_comb begin
            state_d        = state_q;
            deny_acc       = 1'b0;
            tl_d_o         = tl_h_i;
            tl_d_o.a_valid = 1'b0;
            tl_h_o         = tl_d_i;
            tl_h_o.a_ready = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tl_h_i.a_valid && !allowed) begin
                        if (cnt_zero) begin
                            tl_h_o.a_ready = 1'b1;
                            deny_acc       = 1'b1;
                            state_d        = StErrRsp;
                        end else begin
                            state_d = StDrain;
                        end
                    end else begin
                        tl_d_o.a_valid = tl_h_i.a_valid && !cnt_full;
                        tl_h_o.a_ready = tl_d_i.a_ready && !cnt_full;
                    end
                end
                // Hold the denied request until earlier device responses return.
                StDrain: begin
                    if (!tl_h_i.a_valid) begin
                        state_d = StIdle;
                    end else if (cnt_zero) begin
                        tl_h_o.a_ready = 1'b1;
                        deny_acc       = 1'b1;
                        state_d        = StErrRsp;
                    end
                end
                StErrRsp: begin
                    tl_h_o         = err_rsp_intg;
                    tl_d_o.d_ready = 1'b0;
                    if (tl_h_i.d_ready) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        assign fwd_hs   = tl_d_o.a_valid & tl_d_i.a_ready;
        assign dev_d_hs = tl_d_i.d_valid & tl_d_o.d_ready;

        always_comb begin
            cnt_d = cnt_q;
            if (fwd_hs && !dev_d_hs && !cnt_full) begin
                cnt_d = cnt_q + 1'b1;
            end else if (dev_d_hs && !fwd_hs && !cnt_zero) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                src_q   <= '0;
                size_q  <= '0;
                read_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                if (deny_acc) begin
                    src_q  <= tl_h_i.a_source;
                    size_q <= tl_h_i.a_size;
                    read_q <= is_read;
                end
            end
        end

        tlul_racl_err_log u_err_log (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .capture_i (deny_acc),
            .clr_i     (racl_error_clr_i),
            .role_i    (role),
            .ctn_uid_i (tlul_extract_ctn_uid_bits(tl_h_i.a_user.rsvd)),
            .read_i    (is_read),
            .addr_i    (tl_h_i.a_address),
            .log_o     (racl_error_o)
        );

    end else begin : g_bypass

        assign tl_d_o       = tl_h_i;
        assign tl_h_o       = tl_d_i;
        assign racl_error_o = '0;

        logic unused_bypass;
        assign unused_bypass = ^{clk_i, rst_ni, racl_error_clr_i};

    end

endmodule

// File: tb/tb_tlul_racl_gate.sv
// Directed bench for the TL-UL RACL gate.
module tb_tlul_racl_gate;

    import tlul_pkg::*;
    import top_racl_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             clr;
    racl_policy_vec_t pol;
    tl_h2d_t          h2d;
    tl_d2h_t          h_rsp;
    tl_h2d_t          d_req;
    tl_d2h_t          dev;
    racl_error_log_t  elog;

    int n_chk;
    int n_err;

    tlul_racl_gate #(
        .EnableRacl     (1'b1),
        .RaclPolicySel  (0),
        .MaxOutstanding (2)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .racl_policies_i  (pol),
        .tl_h_i           (h2d),
        .tl_h_o           (h_rsp),
        .tl_d_o           (d_req),
        .tl_d_i           (dev),
        .racl_error_o     (elog),
        .racl_error_clr_i (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_req(input tl_a_op_e op, input logic [31:0] addr,
                            input logic [7:0] src, input logic role,
                            input logic [7:0] uid);
        h2d.a_valid        = 1'b1;
        h2d.a_opcode       = op;
        h2d.a_size         = 2'd2;
        h2d.a_mask         = 4'hF;
        h2d.a_source       = src;
        h2d.a_address      = addr;
        h2d.a_data         = 32'h0;
        h2d.a_user.rsvd    = {uid, role};
    endtask

    task automatic host_idle();
        h2d.a_valid = 1'b0;
    endtask

    task automatic dev_rsp(input logic [7:0] src, input logic [31:0] data);
        dev.d_valid  = 1'b1;
        dev.d_opcode = AccessAckData;
        dev.d_size   = 2'd2;
        dev.d_source = src;
        dev.d_data   = data;
        dev.d_error  = 1'b0;
    endtask

    task automatic clear_log();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        pol[0].read_perm  = 2'b01;
        pol[0].write_perm = 2'b10;
        pol[1].read_perm  = 2'b11;
        pol[1].write_perm = 2'b11;
        h2d         = '0;
        h2d.d_ready = 1'b1;
        dev         = '0;
        dev.a_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_dvalid", h_rsp.d_valid, 0);
        check("rst_log", elog, 0);
        check("rst_dev_avalid", d_req.a_valid, 0);
        check("rst_aready", h_rsp.a_ready, 1);
        rst_n = 1'b1;
        tick();

        // Allowed Get role 0
        host_req(Get, 32'h100, 8'd3, 1'b0, 8'h00);
        #1;
        check("get_fwd_valid", d_req.a_valid, 1);
        check("get_fwd_addr", d_req.a_address, 32'h100);
        check("get_aready", h_rsp.a_ready, 1);
        tick();
        host_idle();
        dev_rsp(8'd3, 32'hCAFEF00D);
        #1;
        check("get_dvalid", h_rsp.d_valid, 1);
        check("get_ddata", h_rsp.d_data, 32'hCAFEF00D);
        check("get_derror", h_rsp.d_error, 0);
        tick();
        dev.d_valid = 1'b0;
        #1;
        check("get_log_zero", elog, 0);

        // Denied PutFull role 0
        h2d.d_ready = 1'b0;
        host_req(PutFullData, 32'h200, 8'd5, 1'b0, 8'h11);
        #1;
        check("put_no_fwd", d_req.a_valid, 0);
        check("put_aready", h_rsp.a_ready, 1);
        tick();
        host_idle();
        #1;
        check("put_err_dvalid", h_rsp.d_valid, 1);
        check("put_err_derror", h_rsp.d_error, 1);
        check("put_err_opcode", h_rsp.d_opcode, AccessAck);
        check("put_err_source", h_rsp.d_source, 5);
        check("put_err_size", h_rsp.d_size, 2);
        check("put_err_no_fwd", d_req.a_valid, 0);
        check("put_log_valid", elog.valid, 1);
        check("put_log_ovf", elog.overflow, 0);
        check("put_log_read", elog.read_access, 0);
        check("put_log_addr", elog.request_address, 32'h200);
        tick();
        check("put_err_hold", h_rsp.d_valid, 1);
        h2d.d_ready = 1'b1;
        tick();
        check("put_err_done", h_rsp.d_valid, 0);
        clear_log();
        check("clr_log", elog, 0);

        // Back-to-back denied Gets role 1
        host_req(Get, 32'h10, 8'd7, 1'b1, 8'hA5);
        #1;
        check("b2b1_aready", h_rsp.a_ready, 1);
        tick();
        host_req(Get, 32'h20, 8'd8, 1'b1, 8'h3C);
        #1;
        check("b2b_block", h_rsp.a_ready, 0);
        check("b2b1_opcode", h_rsp.d_opcode, AccessAckData);
        check("b2b1_data", h_rsp.d_data, 32'hFFFFFFFF);
        check("b2b1_source", h_rsp.d_source, 7);
        tick();
        check("b2b2_aready", h_rsp.a_ready, 1);
        check("b2b_gap", h_rsp.d_valid, 0);
        tick();
        host_idle();
        #1;
        check("b2b2_opcode", h_rsp.d_opcode, AccessAckData);
        check("b2b2_data", h_rsp.d_data, 32'hFFFFFFFF);
        check("b2b2_source", h_rsp.d_source, 8);
        check("b2b_log_ovf", elog.overflow, 1);
        check("b2b_log_addr", elog.request_address, 32'h10);
        check("b2b_log_uid", elog.ctn_uid, 8'hA5);
        check("b2b_log_role", elog.racl_role, 1);
        check("b2b_log_read", elog.read_access, 1);
        tick();
        clear_log();

        // Outstanding Get, then denied Put must drain first
        host_req(Get, 32'h40, 8'd1, 1'b0, 8'h00);
        #1;
        check("drain_get_fwd", d_req.a_valid, 1);
        tick();
        host_req(PutFullData, 32'h50, 8'd2, 1'b0, 8'h00);
        #1;
        check("drain_aready0", h_rsp.a_ready, 0);
        check("drain_no_fwd", d_req.a_valid, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("drain_wait%0d", i), h_rsp.a_ready, 0);
        end
        dev_rsp(8'd1, 32'h12345678);
        #1;
        check("drain_dev_dvalid", h_rsp.d_valid, 1);
        check("drain_dev_source", h_rsp.d_source, 1);
        check("drain_dev_error", h_rsp.d_error, 0);
        check("drain_still_block", h_rsp.a_ready, 0);
        tick();
        dev.d_valid = 1'b0;
        #1;
        check("drain_accept", h_rsp.a_ready, 1);
        check("drain_no_rsp", h_rsp.d_valid, 0);
        tick();
        host_idle();
        #1;
        check("drain_err_dvalid", h_rsp.d_valid, 1);
        check("drain_err_source", h_rsp.d_source, 2);
        check("drain_err_derror", h_rsp.d_error, 1);
        tick();

        // Clear and denial in the same cycle
        h2d.d_ready = 1'b0;
        host_req(PutFullData, 32'h30, 8'd4, 1'b0, 8'h00);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        host_idle();
        #1;
        check("clrden_valid", elog.valid, 1);
        check("clrden_ovf", elog.overflow, 0);
        check("clrden_addr", elog.request_address, 32'h30);
        check("clrden_dvalid", h_rsp.d_valid, 1);

        // Reset in the middle of an error response
        rst_n = 1'b0;
        #1;
        check("rstmid_dvalid", h_rsp.d_valid, 0);
        check("rstmid_log", elog, 0);
        tick();
        rst_n = 1'b1;
        h2d.d_ready = 1'b1;
        tick();

        // Outstanding limit of two
        host_req(Get, 32'h60, 8'd1, 1'b0, 8'h00);
        #1;
        check("cap_fwd1", d_req.a_valid, 1);
        tick();
        host_req(Get, 32'h64, 8'd2, 1'b0, 8'h00);
        #1;
        check("cap_fwd2", d_req.a_valid, 1);
        tick();
        host_req(Get, 32'h68, 8'd3, 1'b0, 8'h00);
        #1;
        check("cap_block_valid", d_req.a_valid, 0);
        check("cap_block_ready", h_rsp.a_ready, 0);
        dev_rsp(8'd1, 32'h0);
        #1;
        check("cap_block_same", d_req.a_valid, 0);
        tick();
        dev.d_valid = 1'b0;
        #1;
        check("cap_release", d_req.a_valid, 1);
        check("cap_release_addr", d_req.a_address, 32'h68);
        tick();
        host_idle();
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
